// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, states and helpers for the EX-stage mul/div unit
//
// Purpose : op encodings, FSM state type, iteration count and the
//           divide-by-zero quotient shared by ex_muldiv_unit and its bench.
// Ports   : none (package)

package muldiv_pkg;

   // Operation encodings as driven by the ID/EX register
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // One shift-add or shift-subtract step per operand bit
   localparam int MD_ITER = 32;

   // Quotient returned when the divisor is zero
   localparam logic [31:0] MD_DZ_QUO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } md_state_e;

   // Magnitude of a 32-bit operand; unsigned ops pass the raw value.
   // |0x80000000| is 0x80000000, which is correct when read as unsigned.
   function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negate of a {hi, lo} pair
//
// Purpose : applies result signs in the FIX step. With link_i set the pair is
//           treated as one 64-bit value (product); with link_i clear hi and lo
//           are negated independently (remainder, quotient).
// Ports   :
//   hi_i, lo_i       in  32  unsigned magnitude words
//   neg_hi_i         in  1   negate the hi word
//   neg_lo_i         in  1   negate the lo word
//   link_i           in  1   propagate the lo carry into hi (64-bit negate)
//   hi_o, lo_o       out 32  signed result words

module md_sign_fix (
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        neg_hi_i,
   input  logic        neg_lo_i,
   input  logic        link_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic hi_carry;

   always_comb begin
      // -(H:L) = (~H:~L) + 1; the +1 only reaches H when L is zero
      hi_carry = link_i ? (lo_i == 32'd0) : 1'b1;
      lo_o     = neg_lo_i ? (~lo_i + 32'd1) : lo_i;
      hi_o     = neg_hi_i ? (~hi_i + {31'd0, hi_carry}) : hi_i;
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit for the EX stage
//
// Purpose : computes a 64-bit {hi, lo} result over ITER shift steps plus one
//           sign-fix step. busy holds the pipeline front; done pulses once
//           when hi/lo are loaded.
// Config  : MULDIV_FAST_MUL_EN - multiplies use a single-cycle array multiply
//           (done one edge after start); divides keep the iterative path.
// Ports   :
//   clk      in  1   clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   launch an operation (sampled in IDLE only)
//   cancel   in  1   pipeline flush, aborts any operation
//   op       in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in  32  rs operand (multiplicand / dividend)
//   b        in  32  rt operand (multiplier / divisor)
//   busy     out 1   operation in flight
//   done     out 1   one-cycle pulse, hi/lo valid from here
//   hi       out 32  product upper word / remainder
//   lo       out 32  product lower word / quotient

module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = MD_ITER
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            cancel,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

   md_state_e         state_q;
   logic [5:0]        cnt_q;
   logic              is_div_q;
   logic              neg_hi_q;
   logic              neg_lo_q;
   logic              dz_q;
   logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
   logic [XLEN-1:0]   a_q;        // raw dividend, returned in hi on divide by zero
   logic [2*XLEN-1:0] acc_q;      // {partial product | remainder, multiplier | quotient}
   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;

   logic              signed_op;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   fix_hi;
   logic [XLEN-1:0]   fix_lo;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
`endif

   always_comb begin
      signed_op = ~op[0];
      mag_a     = md_abs(a, signed_op);
      mag_b     = md_abs(b, signed_op);

      // Shift-add: add the multiplicand into the upper half when the current
      // multiplier bit (acc LSB) is set, then shift the whole pair right.
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};

      // Restoring divide: shift the next dividend bit into the remainder and
      // keep the difference only when it did not borrow.
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
   end

`ifdef MULDIV_FAST_MUL_EN
   assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

   // Product: one 64-bit negate. Divide: quotient and remainder separately.
   md_sign_fix u_sign_fix (
      .hi_i     (acc_q[2*XLEN-1:XLEN]),
      .lo_i     (acc_q[XLEN-1:0]),
      .neg_hi_i (neg_hi_q),
      .neg_lo_i (neg_lo_q),
      .link_i   (~is_div_q),
      .hi_o     (fix_hi),
      .lo_o     (fix_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_hi_q <= 1'b0;
         neg_lo_q <= 1'b0;
         dz_q     <= 1'b0;
         opnd_q   <= '0;
         a_q      <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (cancel) begin
         // Flush wins over everything, including a same-edge start or FIX;
         // hi/lo keep the last completed result.
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  is_div_q <= op[1];
                  neg_lo_q <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                  // Remainder follows the dividend; a product shares one sign
                  neg_hi_q <= op[1] ? (signed_op & a[XLEN-1])
                                    : (signed_op & (a[XLEN-1] ^ b[XLEN-1]));
                  dz_q     <= op[1] & (b == '0);
                  a_q      <= a;
                  opnd_q   <= op[1] ? mag_b : mag_a;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                  if (op[1]) begin
                     acc_q   <= {{XLEN{1'b0}}, mag_a};
                     state_q <= CALC;
                  end else begin
                     acc_q   <= fast_prod;
                     state_q <= FIX;
                  end
`else
                  acc_q   <= op[1] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                  state_q <= CALC;
`endif
               end
            end

            CALC: begin
               acc_q <= is_div_q ? div_next : mul_next;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == LAST_CNT) begin
                  state_q <= FIX;
               end
            end

            FIX: begin
               // Divide by zero bypasses sign handling: quotient all ones,
               // remainder is the untouched dividend.
               hi_q    <= dz_q ? a_q : fix_hi;
               lo_q    <= dz_q ? MD_DZ_QUO : fix_lo;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit

module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        cancel;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   ex_muldiv_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cancel (cancel),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Reference model: {hi, lo} from native SystemVerilog arithmetic
   function automatic logic [63:0] model(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
      logic signed [63:0] sp;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      case (f_op)
         2'b00: begin
            sp = $signed({{32{fa[31]}}, fa}) * $signed({{32{fb[31]}}, fb});
            return sp;
         end
         2'b01: return {32'd0, fa} * {32'd0, fb};
         2'b10: begin
            if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
            if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = $signed(fa) / $signed(fb);
            sr = $signed(fa) % $signed(fb);
            return {sr, sq};
         end
         default: begin
            if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
            return {fa % fb, fa / fb};
         end
      endcase
   endfunction

   // Called on a falling edge; start is sampled at the next rising edge (E0)
   task automatic launch(input logic [1:0] l_op, input logic [31:0] la, input logic [31:0] lb);
      op    = l_op;
      a     = la;
      b     = lb;
      start = 1'b1;
      exp_q.push_back(model(l_op, la, lb));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat = edges after E0 at which done became visible; bounded wait
   task automatic wait_done(output int lat, output bit seen, output logic busy_first);
      seen       = 1'b0;
      lat        = -1;
      busy_first = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (i == 1) busy_first = busy;
         if (done) begin
            seen = 1'b1;
            lat  = i - 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n  = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      #12;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mult;
      int lat; bit seen; logic bf; logic [63:0] e;
      launch(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != MUL_LAT) begin
         errors++;
         $display("FAIL mult_latency: seen=%0d lat=%0d, required %0d", seen, lat, MUL_LAT);
      end
      checks++;
      if (bf !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mult_busy: first=%b at_done=%b, required 1 then 0", bf, busy);
      end
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || {hi, lo} !== e) begin
         errors++;
         $display("FAIL mult_result: %h, required %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: done=%b, required 0", done);
      end
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != MUL_LAT || {hi, lo} !== 64'hFFFF_FFFE_0000_0001 || {hi, lo} !== e) begin
         errors++;
         $display("FAIL multu_result: seen=%0d lat=%0d %h, required %h", seen, lat, {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      end
   endtask

   task automatic test_div;
      int lat; bit seen; logic bf; logic [63:0] e;
      int n_done;
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != DIV_LAT || bf !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL div_timing: seen=%0d lat=%0d busy_first=%b busy_done=%b, required lat %0d", seen, lat, bf, busy, DIV_LAT);
      end
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || {hi, lo} !== e) begin
         errors++;
         $display("FAIL div_signed: %h, required %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      end
      launch(2'b11, 32'd100, 32'd0);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != DIV_LAT || {hi, lo} !== {32'd100, 32'hFFFF_FFFF} || {hi, lo} !== e) begin
         errors++;
         $display("FAIL divu_by_zero: seen=%0d lat=%0d %h, required %h", seen, lat, {hi, lo}, {32'd100, 32'hFFFF_FFFF});
      end
      // A start while busy must be ignored
      launch(2'b11, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != 28 || {hi, lo} !== e) begin
         errors++;
         $display("FAIL start_while_busy: seen=%0d lat=%0d %h, required lat 28 %h", seen, lat, {hi, lo}, e);
      end
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL start_while_busy_extra_done: %0d pulses, required 0", n_done);
      end
   endtask

   task automatic test_back_to_back;
      int lat; bit seen; logic bf; logic [63:0] e;
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || {hi, lo} !== {32'd0, 32'h8000_0000} || {hi, lo} !== e) begin
         errors++;
         $display("FAIL div_overflow: seen=%0d %h, required %h", seen, {hi, lo}, {32'd0, 32'h8000_0000});
      end
      // Issue next start in the done cycle
      launch(2'b10, 32'd1000, 32'hFFFF_FFFD);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != DIV_LAT || bf !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back_latency: seen=%0d lat=%0d busy_first=%b, required lat %0d", seen, lat, bf, DIV_LAT);
      end
      checks++;
      if ({hi, lo} !== e) begin
         errors++;
         $display("FAIL back_to_back_result: %h, required %h", {hi, lo}, e);
      end
   endtask

   task automatic test_cancel;
      int lat; bit seen; logic bf; logic [63:0] e;
      logic [63:0] prev;
      int n_done;
      prev = {hi, lo};
      launch(2'b11, 32'h1234_5678, 32'h10);
      repeat (10) @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || {hi, lo} !== prev) begin
         errors++;
         $display("FAIL cancel_state: busy=%b %h, required 0 %h", busy, {hi, lo}, prev);
      end
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done != 0 || {hi, lo} !== prev) begin
         errors++;
         $display("FAIL cancel_no_done: %0d pulses %h, required 0 %h", n_done, {hi, lo}, prev);
      end
      // start and cancel on the same edge: cancel wins
      op = 2'b11; a = 32'd77; b = 32'd3; start = 1'b1; cancel = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; cancel = 1'b0; end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_cancel_same_edge: busy=%b, required 0", busy);
      end
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL start_cancel_no_done: %0d pulses, required 0", n_done);
      end
      launch(2'b11, 32'd9, 32'd2);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || {hi, lo} !== {32'd1, 32'd4} || {hi, lo} !== e) begin
         errors++;
         $display("FAIL after_cancel_op: seen=%0d %h, required %h", seen, {hi, lo}, {32'd1, 32'd4});
      end
   endtask

   task automatic test_async_reset;
      int n_done;
`ifdef MULDIV_FAST_MUL_EN
      launch(2'b11, 32'hFFFF_0000, 32'd3);
`else
      launch(2'b00, 32'h1234, 32'h5678);
`endif
      repeat (20) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
      end
      #1 rst_n = 1'b1;
      exp_q.delete();
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      checks++;
      if (n_done != 0 || {hi, lo} !== 64'd0) begin
         errors++;
         $display("FAIL after_reset_idle: %0d active cycles %h, required 0 0", n_done, {hi, lo});
      end
   endtask

   task automatic test_fast_mul;
      int lat; bit seen; logic bf; logic [63:0] e;
      launch(2'b00, 32'd6, 32'd7);
      wait_done(lat, seen, bf);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != MUL_LAT || {hi, lo} !== 64'd42 || {hi, lo} !== e) begin
         errors++;
         $display("FAIL mul_6x7: seen=%0d lat=%0d %h, required lat %0d %h", seen, lat, {hi, lo}, MUL_LAT, 64'd42);
      end
   endtask

   task automatic test_random;
      int lat; bit seen; logic bf; logic [63:0] e;
      logic [1:0] r_op;
      logic [31:0] ra, rb;
      for (int k = 0; k < 14; k++) begin
         r_op = 2'($urandom_range(0, 3));
         ra   = $urandom;
         case (k % 4)
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 20);
            2: rb = -($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         launch(r_op, ra, rb);
         wait_done(lat, seen, bf);
         e = exp_q.pop_front();
         checks++;
         if (!seen || lat != (r_op[1] ? DIV_LAT : MUL_LAT) || {hi, lo} !== e) begin
            errors++;
            $display("FAIL random_%0d: op=%0d a=%h b=%h seen=%0d lat=%0d got %h, required %h",
                     k, r_op, ra, rb, seen, lat, {hi, lo}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_cancel();
      test_async_reset();
      test_fast_mul();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
